// File: rtl/iso7816_t0_tpdu_engine.sv
// ISO 7816-3 T=0 TPDU engine: sends the header, follows procedure bytes,
// moves data between the card and a host-visible buffer, latches SW1/SW2.
module iso7816_t0_tpdu_engine #(
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 start,
    input  logic [7:0]           cla,
    input  logic [7:0]           ins,
    input  logic [7:0]           p1,
    input  logic [7:0]           p2,
    input  logic [7:0]           p3,
    input  logic                 isWrite,
    input  logic [TIMEOUT_W-1:0] wwtCycles,
    input  logic                 bufWe,
    input  logic [ADDR_W-1:0]    bufAddr,
    input  logic [7:0]           bufWdata,
    input  logic [ADDR_W-1:0]    bufRaddr,
    output logic [7:0]           bufRdata,
    output logic [7:0]           txData,
    output logic                 txValid,
    input  logic                 txReady,
    input  logic [7:0]           rxData,
    input  logic                 rxValid,
    input  logic                 rxParityError,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           sw1,
    output logic [7:0]           sw2,
    output logic [2:0]           errCode,
    output logic [ADDR_W:0]      rxCount
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);
    localparam logic [TIMEOUT_W-1:0] ONE = TIMEOUT_W'(1);

    typedef enum logic [2:0] {
        IDLE, SEND_HDR, WAIT_PROC, SEND_DATA, RECV_DATA, WAIT_SW2, DONE
    } tpduState_e;

    tpduState_e state, stateNext;
    logic [7:0] mem [DEPTH];
    logic [7:0] claR, insR, p1R, p2R, p3R, hdrByte;
    logic isWriteR;
    logic [TIMEOUT_W-1:0] wwtR, timer, timerNext;
    logic [8:0] lenCalc, lenR, remaining, remNext, xferLeft, xferNext;
    logic [2:0] hdrIdx, hdrIdxNext, errNext;
    logic [ADDR_W-1:0] index, idxNext;
    logic [7:0] sw1Next, sw2Next;
    logic [ADDR_W:0] rxCountNext;
    logic memWe, capture, waiting;

    // Case 2 with P3=0 asks the card for a full 256-byte block.
    assign lenCalc = (p3 == 8'h00 && !isWrite) ? 9'd256 : {1'b0, p3};
    assign busy = !(state == IDLE || state == DONE);
    assign done = state == DONE;
    assign waiting = state == WAIT_PROC || state == RECV_DATA ||
                     state == WAIT_SW2;

    always_comb begin
        unique case (hdrIdx)
            3'd0:    hdrByte = claR;
            3'd1:    hdrByte = insR;
            3'd2:    hdrByte = p1R;
            3'd3:    hdrByte = p2R;
            default: hdrByte = p3R;
        endcase
    end

    always_comb begin
        stateNext = state;
        hdrIdxNext = hdrIdx;
        remNext = remaining;
        xferNext = xferLeft;
        idxNext = index;
        timerNext = timer;
        sw1Next = sw1;
        sw2Next = sw2;
        errNext = errCode;
        rxCountNext = rxCount;
        memWe = 1'b0;
        capture = 1'b0;
        txValid = 1'b0;
        txData = 8'h00;
        unique case (state)
            IDLE: if (start) begin
                capture = 1'b1;
                sw1Next = 8'h00;
                sw2Next = 8'h00;
                errNext = 3'd0;
                rxCountNext = '0;
                hdrIdxNext = 3'd0;
                if (lenCalc > DEPTH9) begin
                    errNext = 3'd2;
                    stateNext = DONE;
                end else begin
                    stateNext = SEND_HDR;
                end
            end
            SEND_HDR: begin
                txValid = 1'b1;
                txData = hdrByte;
                if (txReady) begin
                    if (hdrIdx == 3'd4) begin
                        stateNext = WAIT_PROC;
                        remNext = lenR;
                        idxNext = '0;
                        timerNext = wwtR;
                    end else begin
                        hdrIdxNext = hdrIdx + 3'd1;
                    end
                end
            end
            WAIT_PROC: if (rxValid) begin
                timerNext = wwtR;
                if (rxParityError) begin
                    errNext = 3'd4;
                    stateNext = DONE;
                end else if (rxData == 8'h60) begin
                    stateNext = WAIT_PROC;
                end else if (rxData == insR || rxData == ~insR) begin
                    if (remaining == '0) begin
                        errNext = 3'd3;
                        sw1Next = rxData;
                        stateNext = DONE;
                    end else begin
                        xferNext = (rxData == insR) ? remaining : 9'd1;
                        stateNext = isWriteR ? SEND_DATA : RECV_DATA;
                    end
                end else if (rxData[7:4] == 4'h6 || rxData[7:4] == 4'h9) begin
                    sw1Next = rxData;
                    stateNext = WAIT_SW2;
                end else begin
                    errNext = 3'd3;
                    sw1Next = rxData;
                    stateNext = DONE;
                end
            end
            SEND_DATA: begin
                txValid = 1'b1;
                txData = mem[index];
                if (txReady) begin
                    idxNext = index + 1'b1;
                    remNext = remaining - 1'b1;
                    xferNext = xferLeft - 1'b1;
                    if (xferLeft == 9'd1) begin
                        stateNext = WAIT_PROC;
                        timerNext = wwtR;
                    end
                end
            end
            RECV_DATA: if (rxValid) begin
                timerNext = wwtR;
                if (rxParityError) begin
                    errNext = 3'd4;
                    stateNext = DONE;
                end else begin
                    memWe = 1'b1;
                    idxNext = index + 1'b1;
                    remNext = remaining - 1'b1;
                    xferNext = xferLeft - 1'b1;
                    rxCountNext = rxCount + 1'b1;
                    if (xferLeft == 9'd1) stateNext = WAIT_PROC;
                end
            end
            WAIT_SW2: if (rxValid) begin
                stateNext = DONE;
                if (rxParityError) begin
                    errNext = 3'd4;
                end else begin
                    sw2Next = rxData;
                    errNext = 3'd0;
                end
            end
            DONE: stateNext = IDLE;
        endcase
        // Card silence: the counter runs only while a byte is owed.
        if (waiting && !rxValid) begin
            if (timer <= ONE) begin
                errNext = 3'd1;
                stateNext = DONE;
            end else begin
                timerNext = timer - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else state <= stateNext;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            {claR, insR, p1R, p2R, p3R} <= '0;
            isWriteR <= 1'b0;
            wwtR <= '0;
            lenR <= '0;
            hdrIdx <= '0;
            remaining <= '0;
            xferLeft <= '0;
            index <= '0;
            timer <= '0;
            sw1 <= 8'h00;
            sw2 <= 8'h00;
            errCode <= 3'd0;
            rxCount <= '0;
        end else begin
            if (capture) begin
                {claR, insR, p1R, p2R, p3R} <= {cla, ins, p1, p2, p3};
                isWriteR <= isWrite;
                wwtR <= wwtCycles;
                lenR <= lenCalc;
            end
            hdrIdx <= hdrIdxNext;
            remaining <= remNext;
            xferLeft <= xferNext;
            index <= idxNext;
            timer <= timerNext;
            sw1 <= sw1Next;
            sw2 <= sw2Next;
            errCode <= errNext;
            rxCount <= rxCountNext;
        end
    end

    // Buffer contents are not reset; host writes are locked out while busy.
    always_ff @(posedge clk) begin
        if (memWe) mem[index] <= rxData;
        else if (bufWe && !busy) mem[bufAddr] <= bufWdata;
        bufRdata <= mem[bufRaddr];
    end
endmodule

// File: tb/tb_iso7816_t0_tpdu_engine.sv
// Directed bench for the T=0 TPDU engine with a transaction-level card model
// and a per-cycle compare process on the tx stream and completion outputs.
module tb_iso7816_t0_tpdu_engine;
    localparam int AW = 4;
    localparam int TW = 24;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic start = 1'b0;
    logic [7:0] cla = 0, ins = 0, p1 = 0, p2 = 0, p3 = 0;
    logic isWrite = 1'b0;
    logic [TW-1:0] wwtCycles = '0;
    logic bufWe = 1'b0;
    logic [AW-1:0] bufAddr = '0, bufRaddr = '0;
    logic [7:0] bufWdata = 8'h00, bufRdata, txData, rxData = 8'h00;
    logic txValid, txReady = 1'b1, rxValid = 1'b0, rxParityError = 1'b0;
    logic busy, done;
    logic [7:0] sw1, sw2;
    logic [2:0] errCode;
    logic [AW:0] rxCount;

    always #5 clk = ~clk;

    iso7816_t0_tpdu_engine #(.ADDR_W(AW), .TIMEOUT_W(TW)) dut (
        .clk(clk), .nReset(nReset), .start(start),
        .cla(cla), .ins(ins), .p1(p1), .p2(p2), .p3(p3),
        .isWrite(isWrite), .wwtCycles(wwtCycles),
        .bufWe(bufWe), .bufAddr(bufAddr), .bufWdata(bufWdata),
        .bufRaddr(bufRaddr), .bufRdata(bufRdata),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .rxParityError(rxParityError),
        .busy(busy), .done(done), .sw1(sw1), .sw2(sw2),
        .errCode(errCode), .rxCount(rxCount)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model state: scenario inputs and expected results.
    logic [7:0] sCla, sIns, sP1, sP2, sP3;
    logic sWr;
    logic [7:0] cardQ[$];
    int parIdx = -1;
    logic [7:0] bufInit [DEPTH];
    logic [7:0] mBuf [DEPTH];
    logic [7:0] expTx[$];
    logic [7:0] expSw1 = 0, expSw2 = 0;
    logic [2:0] expErr = 0;
    logic [AW:0] expRx = 0;

    // Walk the card's reply as a byte list; running out of bytes means
    // the card went silent, i.e. a timeout.
    task automatic buildModel();
        int len, rem, idx, k, n;
        logic [7:0] b;
        expTx.delete();
        expSw1 = 0; expSw2 = 0; expErr = 0; expRx = 0;
        for (int a = 0; a < DEPTH; a++) mBuf[a] = bufInit[a];
        len = (sP3 == 8'h00 && !sWr) ? 256 : int'(sP3);
        if (len > DEPTH) begin expErr = 2; return; end
        expTx = '{sCla, sIns, sP1, sP2, sP3};
        rem = len; idx = 0; k = 0;
        forever begin
            if (k >= cardQ.size()) begin expErr = 1; return; end
            if (k == parIdx) begin expErr = 4; return; end
            b = cardQ[k]; k++;
            if (b == 8'h60) continue;
            if (b == sIns || b == ~sIns) begin
                if (rem == 0) begin expErr = 3; expSw1 = b; return; end
                n = (b == sIns) ? rem : 1;
                for (int j = 0; j < n; j++) begin
                    if (sWr) expTx.push_back(mBuf[idx]);
                    else begin
                        if (k >= cardQ.size()) begin expErr = 1; return; end
                        if (k == parIdx) begin expErr = 4; return; end
                        mBuf[idx] = cardQ[k]; k++; expRx++;
                    end
                    idx++; rem--;
                end
            end else if (b[7:4] == 4'h6 || b[7:4] == 4'h9) begin
                expSw1 = b;
                if (k >= cardQ.size()) begin expErr = 1; return; end
                if (k == parIdx) begin expErr = 4; return; end
                expSw2 = cardQ[k];
                return;
            end else begin
                expErr = 3; expSw1 = b; return;
            end
        end
    endtask

    int doneCount = 0, doneCyc = 0, hsCyc = 0, startCyc = 0, txvCount = 0;
    logic prevV = 0, prevR = 0, prevN = 0;
    logic [7:0] prevD = 0;

    always @(negedge clk) begin
        if (nReset && prevN && prevV && !prevR)
            chk("txHold", 32'({txValid, txData}), 32'({1'b1, prevD}));
        if (txValid) txvCount++;
        if (start) startCyc = cyc;
        if (txValid && txReady) begin
            hsCyc = cyc;
            if (expTx.size() == 0) begin
                checks++; errors++;
                $display("FAIL txExtra actual=%0h required=none", txData);
            end else begin
                chk("txByte", 32'(txData), 32'(expTx.pop_front()));
            end
        end
        if (done) begin
            doneCount++;
            doneCyc = cyc;
            chk("doneBusy", 32'(busy), 32'd0);
            chk("doneSw1", 32'(sw1), 32'(expSw1));
            chk("doneSw2", 32'(sw2), 32'(expSw2));
            chk("doneErr", 32'(errCode), 32'(expErr));
            chk("doneRxCount", 32'(rxCount), 32'(expRx));
        end
        prevV = txValid; prevR = txReady; prevD = txData; prevN = nReset;
    end

    task automatic loadBuffer();
        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk); #1;
            bufWe = 1'b1; bufAddr = AW'(a); bufWdata = bufInit[a];
        end
        @(posedge clk); #1;
        bufWe = 1'b0;
    endtask

    task automatic readBuf(input int a, output logic [7:0] v);
        @(posedge clk); #1;
        bufRaddr = AW'(a);
        @(posedge clk); #1;
        v = bufRdata;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic par);
        int q = 0;
        int n = 0;
        while (q < 2 && n < 400) begin
            @(negedge clk);
            q = txValid ? 0 : q + 1;
            n++;
        end
        if (q < 2) begin
            checks++; errors++;
            $display("FAIL quietWait actual=txActive required=txIdle");
        end
        @(posedge clk); #1;
        rxValid = 1'b1; rxData = b; rxParityError = par;
        @(posedge clk); #1;
        rxValid = 1'b0; rxParityError = 1'b0;
    endtask

    task automatic startTpdu(input logic [7:0] c, i, a1, a2, p,
                             input logic wr, input int wwt, input int stall);
        sCla = c; sIns = i; sP1 = a1; sP2 = a2; sP3 = p; sWr = wr;
        loadBuffer();
        buildModel();
        @(posedge clk); #1;
        cla = c; ins = i; p1 = a1; p2 = a2; p3 = p; isWrite = wr;
        wwtCycles = TW'(wwt); start = 1'b1; txReady = (stall == 0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic runTpdu(input logic [7:0] c, i, a1, a2, p,
                           input logic wr, input int wwt, input int stall);
        int d0;
        logic [7:0] v;
        d0 = doneCount;
        startTpdu(c, i, a1, a2, p, wr, wwt, stall);
        if (stall > 0) begin
            bufWe = 1'b1; bufAddr = AW'(7); bufWdata = 8'hEE;
            repeat (stall) @(posedge clk);
            #1;
            bufWe = 1'b0; txReady = 1'b1;
        end
        for (int k = 0; k < cardQ.size(); k++) begin
            if (doneCount != d0) break;
            sendByte(cardQ[k], k == parIdx);
        end
        for (int n = 0; n < wwt + 300 && doneCount == d0; n++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        chk("donePulses", 32'(doneCount - d0), 32'd1);
        chk("txLeft", 32'(expTx.size()), 32'd0);
        chk("errHold", 32'(errCode), 32'(expErr));
        chk("sw1Hold", 32'(sw1), 32'(expSw1));
        for (int a = 0; a < DEPTH; a++) begin
            readBuf(a, v);
            chk("buf", 32'(v), 32'(mBuf[a]));
        end
    endtask

    initial begin
        int d0, tv0, n;
        logic [7:0] v;
        for (int a = 0; a < DEPTH; a++) bufInit[a] = 8'(8'h30 + a);
        repeat (3) @(posedge clk);
        #1;
        chk("rstTxValid", 32'(txValid), 32'd0);
        chk("rstBusy", 32'(busy), 32'd0);
        chk("rstDone", 32'(done), 32'd0);
        chk("rstSw", 32'({sw1, sw2}), 32'd0);
        chk("rstErr", 32'(errCode), 32'd0);
        chk("rstRxCount", 32'(rxCount), 32'd0);
        nReset = 1'b1;
        repeat (2) @(posedge clk);

        // Case 3 with a 50-cycle txReady stall and a locked-out host write.
        bufInit[0] = 8'h55;
        cardQ = '{8'h0C, 8'h90, 8'h00}; parIdx = -1;
        runTpdu(8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 1'b1, 1000, 50);
        chk("c3Sw", 32'({sw1, sw2}), 32'h9000);
        chk("c3Err", 32'(errCode), 32'd0);

        // Case 2, byte by byte with a NULL in between.
        cardQ = '{8'hF3, 8'hAA, 8'h60, 8'hF3, 8'hBB, 8'h61, 8'h10};
        runTpdu(8'h00, 8'h0C, 8'h00, 8'h00, 8'h02, 1'b0, 1000, 0);
        chk("c2Sw", 32'({sw1, sw2}), 32'h6110);
        chk("c2RxCount", 32'(rxCount), 32'd2);
        readBuf(0, v);
        chk("c2Buf0", 32'(v), 32'hAA);
        readBuf(1, v);
        chk("c2Buf1", 32'(v), 32'hBB);

        // Silent card after the header.
        cardQ = {};
        runTpdu(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04, 1'b0, 100, 0);
        chk("toErr", 32'(errCode), 32'd1);
        chk("toCycles", 32'(doneCyc - hsCyc - 1), 32'd100);

        // Le=256 does not fit a 16-byte buffer.
        tv0 = txvCount;
        runTpdu(8'h00, 8'hB0, 8'h00, 8'h00, 8'h00, 1'b0, 100, 0);
        chk("lenErr", 32'(errCode), 32'd2);
        chk("lenDoneLat", 32'(doneCyc - startCyc), 32'd1);
        chk("lenNoTx", 32'(txvCount - tv0), 32'd0);

        // Parity error on the second data byte.
        cardQ = '{8'h0C, 8'hAA, 8'h55}; parIdx = 2;
        runTpdu(8'h00, 8'h0C, 8'h00, 8'h00, 8'h03, 1'b0, 1000, 0);
        chk("parErr", 32'(errCode), 32'd4);
        chk("parRxCount", 32'(rxCount), 32'd1);
        parIdx = -1;

        // Unknown procedure byte, then INS with nothing left to move.
        cardQ = '{8'h42};
        runTpdu(8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 1'b1, 1000, 0);
        chk("badProc", 32'({errCode, sw1}), 32'({3'd3, 8'h42}));
        cardQ = '{8'h0C};
        runTpdu(8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 1'b1, 1000, 0);
        chk("insNoRem", 32'({errCode, sw1}), 32'({3'd3, 8'h0C}));

        // Reset pulse while sending data: abort without done.
        d0 = doneCount;
        cardQ = '{8'hD6};
        startTpdu(8'h00, 8'hD6, 8'h00, 8'h00, 8'h04, 1'b1, 1000, 0);
        sendByte(8'hD6, 1'b0);
        txReady = 1'b0;
        n = 0;
        while (!txValid && n < 50) begin @(negedge clk); n++; end
        chk("abortInData", 32'(txValid), 32'd1);
        @(posedge clk); #1;
        nReset = 1'b0;
        #1;
        chk("abortTxValid", 32'(txValid), 32'd0);
        chk("abortBusy", 32'(busy), 32'd0);
        chk("abortDone", 32'(done), 32'd0);
        chk("abortStatus", 32'({sw1, sw2, errCode, rxCount}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        nReset = 1'b1; txReady = 1'b1;
        expTx.delete();
        repeat (5) @(negedge clk);
        chk("abortNoDonePulse", 32'(doneCount - d0), 32'd0);

        // First start after release: full-length case 3.
        bufInit[0] = 8'h11; bufInit[1] = 8'h22; bufInit[2] = 8'h33;
        cardQ = '{8'hD6, 8'h90, 8'h00};
        runTpdu(8'h80, 8'hD6, 8'h01, 8'h02, 8'h03, 1'b1, 1000, 0);
        chk("postRstSw", 32'({sw1, sw2}), 32'h9000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/iso7816_t0_tpdu_engine.md
ISO7816_T0_TPDU_ENGINE -- requirements
Module: iso7816_t0_tpdu_engine

Interface
REQ-001 Parameter ADDR_W, default 4, data buffer address width; buffer depth DEPTH = 2**ADDR_W bytes (legal 2..8).
REQ-002 Parameter TIMEOUT_W, default 24, width of the waiting-time counter and of wwtCycles.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 nReset  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle pulse in IDLE launches a TPDU; ignored when busy=1.
REQ-006 cla, ins, p1, p2, p3  in  8 each  header bytes, captured on the start cycle.
REQ-007 isWrite  in  1  1 = host-to-card data (case 3), 0 = card-to-host data (case 2); captured on start.
REQ-008 wwtCycles  in  TIMEOUT_W  max clk cycles allowed between bytes received from the card; captured on start.
REQ-009 bufWe, bufAddr[ADDR_W-1:0], bufWdata[7:0]  in  host write port to the data buffer.
REQ-010 bufRaddr[ADDR_W-1:0]  in, bufRdata[7:0]  out  host read port, 1-cycle registered latency.
REQ-011 txData[7:0], txValid  out; txReady  in  byte stream to the ISO 7816 UART.
REQ-012 rxData[7:0], rxValid, rxParityError  in  byte from the UART; rxValid is a 1-cycle strobe.
REQ-013 busy, done  out  1 each  busy=1 outside IDLE/DONE; done=1 pulses one cycle at TPDU end.
REQ-014 sw1, sw2  out  8 each  status word of last TPDU; errCode  out  3  0 none, 1 timeout, 2 length, 3 bad procedure byte, 4 parity.
REQ-015 rxCount  out  ADDR_W+1  number of data bytes stored from card in last TPDU.

Function
REQ-016 States: IDLE, SEND_HDR, WAIT_PROC, SEND_DATA, RECV_DATA, WAIT_SW2, DONE; DONE returns to IDLE after one cycle.
REQ-017 Transfer length L = p3, except L = 256 when p3=0 and isWrite=0.
REQ-018 On start with L > DEPTH: no bytes sent, errCode=2, sw1=sw2=8'h00, done pulse next cycle.
REQ-019 Tx handshake: txValid held with txData stable until a cycle with txValid=1 and txReady=1; next byte presented no earlier than the following cycle.
REQ-020 SEND_HDR sends cla, ins, p1, p2, p3 in order, then enters WAIT_PROC with remaining = L, index = 0.
REQ-021 WAIT_PROC on rxValid: 8'h60 stays in WAIT_PROC (NULL, timer restarted).
REQ-022 WAIT_PROC byte == ins: transfer all remaining bytes (SEND_DATA if isWrite else RECV_DATA), then back to WAIT_PROC.
REQ-023 WAIT_PROC byte == ~ins: transfer exactly one byte, then back to WAIT_PROC.
REQ-024 WAIT_PROC byte with high nibble 6 or 9 (not 8'h60): latch sw1, enter WAIT_SW2; next received byte latches sw2, errCode=0, go DONE.
REQ-025 Any other byte in WAIT_PROC, or ins/~ins when remaining=0: errCode=3, sw1 = that byte, go DONE.
REQ-026 SEND_DATA sends buffer[index] and increments index; RECV_DATA writes rxData to buffer[index], increments index and rxCount.
REQ-027 Waiting-time counter reloads to wwtCycles on entry to WAIT_PROC, RECV_DATA, WAIT_SW2 and on every rxValid; reaching 0 in those states gives errCode=1, go DONE.
REQ-028 rxParityError=1 with rxValid in any receiving state: errCode=4, go DONE; byte discarded.
REQ-029 rxValid in IDLE, SEND_HDR or SEND_DATA is ignored.
REQ-030 Host buffer writes are honoured only when busy=0; host reads are always allowed; engine write and host read of the same address in one cycle return the old value.
REQ-031 sw1, sw2, errCode, rxCount cleared on start and hold their values after DONE until the next start.

Reset
REQ-032 nReset low forces immediately: state IDLE, txValid=0, busy=0, done=0, sw1=sw2=0, errCode=0, rxCount=0, counters 0; buffer contents undefined.
REQ-033 nReset asserted mid-TPDU aborts the transfer without a done pulse; the first start after release is honoured.

Verification
REQ-034 Case 3: header 00 0C 00 00 01, buffer[0]=55, card returns 0C, then 90 00 -> tx 00 0C 00 00 01 55, sw1=90, sw2=00, errCode=0, one done pulse.
REQ-035 Case 2 with byte-by-byte transfer: p3=02, card returns F3, AA, 60, F3, BB, 61, 10 -> buffer[0]=AA, buffer[1]=BB, rxCount=2, sw=6110.
REQ-036 Timeout: wwtCycles=100, card silent after header -> errCode=1 exactly 100 cycles after WAIT_PROC entry, done pulse.
REQ-037 Length: ADDR_W=4, isWrite=0, p3=00 -> no txValid, errCode=2, done one cycle after start.
REQ-038 Boundaries: txReady held low 50 cycles (txValid/txData stable); rxParityError during RECV_DATA -> errCode=4; nReset pulse in SEND_DATA -> idle outputs, no done.
